// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Brief    : Y86-64 SEQ program register file, dual write / dual read ports,
//            sticky halt and write-commit counter.
// Revision : 1.0  initial release
// ============================================================================
module reg_file #(
    parameter int                 NREG       = 15,
    parameter int                 WIDTH      = 64,
    parameter int                 RSP_ID     = 4,
    parameter logic [WIDTH-1:0]   STACK_INIT = 64'h0000_0000_0000_0200,
    parameter int                 BYPASS     = 0,
    parameter int                 CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic                halt_in,
    input  logic [3:0]          srcA,
    input  logic [3:0]          srcB,
    input  logic [3:0]          dstE,
    input  logic [3:0]          dstM,
    input  logic [WIDTH-1:0]    valE,
    input  logic [WIDTH-1:0]    valM,
    output logic [WIDTH-1:0]    valA,
    output logic [WIDTH-1:0]    valB,
    input  logic [3:0]          dbg_sel,
    output logic [WIDTH-1:0]    dbg_val,
    output logic                halted,
    output logic [CNT_W-1:0]    wr_count
);

    localparam logic [3:0] c_rnone = 4'hF;

    logic [WIDTH-1:0] r_regs [NREG];
    logic             r_halted;
    logic [CNT_W-1:0] r_count;
    logic             w_commit;
    logic             w_any_wr;
    logic [WIDTH-1:0] w_val_a;
    logic [WIDTH-1:0] w_val_b;
    logic [WIDTH-1:0] w_dbg;

    assign w_commit = wr_en & ~r_halted & rst_n;
    assign w_any_wr = (dstE != c_rnone) | (dstM != c_rnone);

    // M is applied after E so a same-ID dual write leaves valM in the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= (i == RSP_ID) ? STACK_INIT : '0;
            end
            r_halted <= 1'b0;
            r_count  <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < NREG; i++) begin
                if (dstM == 4'(i)) begin
                    r_regs[i] <= valM;
                end else if (dstE == 4'(i)) begin
                    r_regs[i] <= valE;
                end
            end
            if (halt_in) begin
                r_halted <= 1'b1;
            end
            if (w_any_wr) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    function automatic logic [WIDTH-1:0] f_stored(input logic [3:0] sel);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (sel == 4'(i)) begin
                v = r_regs[i];
            end
        end
        return v;
    endfunction

    always_comb begin
        w_dbg = f_stored(dbg_sel);
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            // Pending write data forwarded to the decode ports; M beats E.
            always_comb begin
                w_val_a = f_stored(srcA);
                w_val_b = f_stored(srcB);
                if (w_commit && srcA != c_rnone) begin
                    if (srcA == dstM) begin
                        w_val_a = valM;
                    end else if (srcA == dstE) begin
                        w_val_a = valE;
                    end
                end
                if (w_commit && srcB != c_rnone) begin
                    if (srcB == dstM) begin
                        w_val_b = valM;
                    end else if (srcB == dstE) begin
                        w_val_b = valE;
                    end
                end
            end
        end else begin : g_no_bypass
            always_comb begin
                w_val_a = f_stored(srcA);
                w_val_b = f_stored(srcB);
            end
        end
    endgenerate

    assign valA     = w_val_a;
    assign valB     = w_val_b;
    assign dbg_val  = w_dbg;
    assign halted   = r_halted;
    assign wr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file
// Brief    : Scoreboard bench for reg_file; one BYPASS=0 and one BYPASS=1
//            (narrow counter) instance share the same stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_file;

    localparam logic [3:0] c_rnone = 4'hF;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        halt_in;
    logic [3:0]  srcA, srcB, dstE, dstM, dbg_sel;
    logic [63:0] valE, valM;

    logic [63:0] w_va0, w_vb0, w_dbg0, w_va1, w_vb1, w_dbg1;
    logic        w_halt0, w_halt1;
    logic [31:0] w_cnt0;
    logic [2:0]  w_cnt1;

    reg_file #(.BYPASS(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .halt_in(halt_in),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
        .valE(valE), .valM(valM), .valA(w_va0), .valB(w_vb0),
        .dbg_sel(dbg_sel), .dbg_val(w_dbg0), .halted(w_halt0), .wr_count(w_cnt0)
    );

    reg_file #(.BYPASS(1), .CNT_W(3)) u_byp (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .halt_in(halt_in),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
        .valE(valE), .valM(valM), .valA(w_va1), .valB(w_vb1),
        .dbg_sel(dbg_sel), .dbg_val(w_dbg1), .halted(w_halt1), .wr_count(w_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [63:0] m_reg [15];
    logic        m_halt;
    logic [31:0] m_cnt;

    typedef struct {
        string       tag;
        int          which;
        logic [63:0] exp;
    } sb_t;
    sb_t sb_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int which, input logic [63:0] exp);
        sb_t e;
        e.tag = tag; e.which = which; e.exp = exp;
        sb_q.push_back(e);
    endtask

    function automatic logic [63:0] actual(input int which);
        case (which)
            0: return w_dbg0;
            1: return w_va0;
            2: return w_vb0;
            3: return w_vb1;
            4: return {63'd0, w_halt0};
            5: return {32'd0, w_cnt0};
            6: return {61'd0, w_cnt1};
            7: return w_va1;
            8: return {63'd0, w_halt1};
            default: return 64'hX;
        endcase
    endfunction

    task automatic drain();
        sb_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, actual(e.which), e.exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_reg[i] = (i == 4) ? 64'h200 : 64'h0;
        m_halt = 1'b0;
        m_cnt  = 32'd0;
    endtask

    task automatic idle();
        wr_en = 1'b1; halt_in = 1'b0;
        dstE = c_rnone; dstM = c_rnone; valE = '0; valM = '0;
    endtask

    // One clock: model absorbs the current inputs, DUT sees the edge.
    task automatic cycle();
        if (rst_n && wr_en && !m_halt) begin
            if (dstE != c_rnone) m_reg[dstE] = valE;
            if (dstM != c_rnone) m_reg[dstM] = valM;
            if (dstE != c_rnone || dstM != c_rnone) m_cnt = m_cnt + 1;
            if (halt_in) m_halt = 1'b1;
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] id);
        dbg_sel = id;
        push(tag, 0, m_reg[id]);
        drain();
    endtask

    task automatic chk_state(input string tag);
        push({tag, "_halt"}, 4, {63'd0, m_halt});
        push({tag, "_halt1"}, 8, {63'd0, m_halt});
        push({tag, "_cnt"}, 5, {32'd0, m_cnt});
        push({tag, "_cnt1"}, 6, {61'd0, m_cnt[2:0]});
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; srcA = c_rnone; srcB = c_rnone; dbg_sel = 4'd0;
        idle();
        model_reset();
        #12;
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        for (int i = 0; i < 15; i++) chk_reg($sformatf("rst_reg%0d", i), 4'(i));
        srcA = c_rnone;
        push("rst_srcA_none", 1, 64'h0);
        drain();
        chk_state("rst");

        // Single write
        dstE = 4'd2; valE = 64'hDEAD_BEEF;
        cycle();
        srcA = 4'd2;
        push("single_valA", 1, 64'hDEAD_BEEF);
        drain();
        chk_state("single");

        // Same-ID dual write: M wins, counts once
        dstE = 4'd4; valE = 64'h1F8; dstM = 4'd4; valM = 64'hABCD;
        cycle();
        push("coll_reg4", 0, 64'hABCD); dbg_sel = 4'd4;
        drain();
        chk_state("coll");

        // Distinct dual write (popq %rax)
        dstE = 4'd4; valE = 64'h1F8; dstM = 4'd0; valM = 64'h55;
        cycle();
        chk_reg("pop_rsp", 4'd4);
        chk_reg("pop_rax", 4'd0);
        chk_state("pop");

        // Bypass: old value of reg5 is 0x11
        dstE = 4'd5; valE = 64'h11;
        cycle();
        srcB = 4'd5; dstM = 4'd5; valM = 64'h42; dstE = 4'd5; valE = 64'h99;
        push("byp0_old", 2, 64'h11);
        push("byp1_mwins", 3, 64'h42);
        drain();
        wr_en = 1'b0;
        push("byp1_gated", 3, 64'h11);
        drain();
        wr_en = 1'b1; srcB = c_rnone; dstE = c_rnone; valE = 64'h77;
        push("byp1_none", 3, 64'h0);
        drain();
        dstE = 4'd5; srcA = 4'd5;
        push("byp1_valA_M", 7, 64'h42);
        drain();
        cycle();
        srcB = 4'd5;
        push("byp0_after", 2, 64'h42);
        push("byp1_after", 3, 64'h42);
        drain();

        // Status gating
        wr_en = 1'b0; dstE = 4'd1; valE = 64'd7; halt_in = 1'b1;
        cycle();
        chk_reg("gate_reg1", 4'd1);
        chk_state("gate");

        // Halt, then writes ignored
        halt_in = 1'b1;
        cycle();
        chk_state("halt");
        dstE = 4'd1; valE = 64'd9;
        cycle();
        chk_reg("halted_reg1", 4'd1);
        chk_state("halted");
        srcA = 4'd4;
        push("halted_read", 1, m_reg[4]);
        drain();

        // Async reset mid-cycle
        rst_n = 1'b0; #1; rst_n = 1'b1; model_reset();
        @(negedge clk);
        dstE = 4'd3; valE = 64'h77; halt_in = 1'b1;
        cycle();
        chk_reg("pre_areset_reg3", 4'd3);
        chk_state("pre_areset");
        #2;
        rst_n = 1'b0;
        model_reset();
        dbg_sel = 4'd3;
        push("areset_reg3", 0, 64'h0);
        drain();
        chk_state("areset");
        #2;
        rst_n = 1'b1;
        @(negedge clk);

        // Counter wrap on the 3-bit instance
        for (int i = 0; i < 9; i++) begin
            dstE = 4'd6; valE = 64'(i + 100);
            cycle();
        end
        chk_reg("wrap_reg6", 4'd6);
        chk_state("wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
